// File: rtl/fetch_decode_if.sv
// fetch_decode_if: PC, program-memory, run control and execute-handshake
// signals of the CHIP-8 front end, bundled so the core and its environment
// connect through a single port.
interface fetch_decode_if #(
  parameter int ADDR_W = 12
);
  // run control
  logic              run;
  // PC register side
  logic [15:0]       pc_rd;
  logic              pc_inc_en;
  logic [15:0]       pc_inc_wr;
  // program memory side
  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [15:0]       mem_r_data;
  // execute side
  logic              ex_done;
  logic              dec_valid;
  logic [5:0]        decode;
  logic [3:0]        x;
  logic [3:0]        y;
  logic [3:0]        n;
  logic [7:0]        val;
  logic [11:0]       addr;
  logic [15:0]       opcode;
  logic              illegal;

  // fetch_decode drives the strobes and decoded fields
  modport master (
    input  run,
    input  pc_rd,
    input  mem_r_data,
    input  ex_done,
    output pc_inc_en,
    output pc_inc_wr,
    output mem_r_en,
    output mem_r_addr,
    output dec_valid,
    output decode,
    output x,
    output y,
    output n,
    output val,
    output addr,
    output opcode,
    output illegal
  );

  // environment: PC register, program memory and execute stage
  modport slave (
    output run,
    output pc_rd,
    output mem_r_data,
    output ex_done,
    input  pc_inc_en,
    input  pc_inc_wr,
    input  mem_r_en,
    input  mem_r_addr,
    input  dec_valid,
    input  decode,
    input  x,
    input  y,
    input  n,
    input  val,
    input  addr,
    input  opcode,
    input  illegal
  );
endinterface

// File: rtl/fetch_decode.sv
// fetch_decode: CHIP-8 front end. Fetches the opcode at PC, requests the
// PC increment, decodes the opcode into an operation code plus operand
// fields, issues it to execute and waits for completion before the next
// fetch. Strobes and fields are registered; the only outputs derived
// combinationally are the two that must follow pc_rd in the same cycle.
module fetch_decode #(
  parameter int ADDR_W = 12
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  fetch_decode_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_ISSUE  = 3'd4,
    S_EXEC   = 3'd5
  } state_t;

  // Opcode -> 6-bit operation code; 0 marks an undefined opcode.
  function automatic logic [5:0] f_decode(input logic [15:0] op);
    logic [5:0] code;
    code = 6'd0;
    case (op[15:12])
      4'h0: begin
        if (op == 16'h00E0) begin
          code = 6'd1;
        end else if (op == 16'h00EE) begin
          code = 6'd2;
        end else begin
          code = 6'd0;
        end
      end
      4'h1: code = 6'd3;
      4'h2: code = 6'd4;
      4'h3: code = 6'd5;
      4'h4: code = 6'd6;
      4'h5: code = (op[3:0] == 4'h0) ? 6'd7 : 6'd0;
      4'h6: code = 6'd8;
      4'h7: code = 6'd9;
      4'h8: begin
        case (op[3:0])
          4'h0:    code = 6'd10;
          4'h1:    code = 6'd11;
          4'h2:    code = 6'd12;
          4'h3:    code = 6'd13;
          4'h4:    code = 6'd14;
          4'h5:    code = 6'd15;
          4'h6:    code = 6'd16;
          4'h7:    code = 6'd17;
          4'hE:    code = 6'd18;
          default: code = 6'd0;
        endcase
      end
      4'h9: code = (op[3:0] == 4'h0) ? 6'd19 : 6'd0;
      4'hA: code = 6'd20;
      4'hB: code = 6'd21;
      4'hC: code = 6'd22;
      4'hD: code = 6'd23;
      4'hE: begin
        case (op[7:0])
          8'h9E:   code = 6'd24;
          8'hA1:   code = 6'd25;
          default: code = 6'd0;
        endcase
      end
      4'hF: begin
        // code 31 is intentionally skipped: Fx29 maps to 32
        case (op[7:0])
          8'h07:   code = 6'd26;
          8'h0A:   code = 6'd27;
          8'h15:   code = 6'd28;
          8'h18:   code = 6'd29;
          8'h1E:   code = 6'd30;
          8'h29:   code = 6'd32;
          8'h33:   code = 6'd33;
          8'h55:   code = 6'd34;
          8'h65:   code = 6'd35;
          default: code = 6'd0;
        endcase
      end
      default: code = 6'd0;
    endcase
    return code;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_opcode;
  logic [5:0]  r_decode;
  logic [3:0]  r_x;
  logic [3:0]  r_y;
  logic [3:0]  r_n;
  logic [7:0]  r_val;
  logic [11:0] r_addr;
  logic        r_mem_r_en;
  logic        r_pc_inc_en;
  logic        r_dec_valid;
  logic        r_illegal;

  logic [5:0]        w_code;
  logic              w_legal;
  logic [ADDR_W-1:0] w_mem_r_addr;
  logic [15:0]       w_pc_inc_wr;

  assign w_code  = f_decode(r_opcode);
  assign w_legal = (w_code != 6'd0);

  // Next-state logic; run is consulted only at instruction boundaries.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.run) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_legal) begin
          w_state_nxt = S_ISSUE;
        end else if (bus.run) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE, S_EXEC: begin
        if (!bus.ex_done) begin
          w_state_nxt = S_EXEC;
        end else if (bus.run) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-state strobes registered from the next state so each one is a
  // glitch-free flop that is high exactly while the FSM sits in its state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_r_en  <= 1'b0;
      r_pc_inc_en <= 1'b0;
      r_dec_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_mem_r_en  <= (w_state_nxt == S_FETCH);
      r_pc_inc_en <= (w_state_nxt == S_DECODE);
      r_dec_valid <= (w_state_nxt == S_ISSUE);
      r_illegal   <= (r_state == S_DECODE) && !w_legal;
    end
  end

  // Capture the memory word returned for the fetch issued one cycle earlier.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_opcode <= 16'h0000;
    end else if (r_state == S_WAIT) begin
      r_opcode <= bus.mem_r_data;
    end
  end

  // Register decoded fields; they hold until the next DECODE, even in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_decode <= 6'd0;
      r_x      <= 4'h0;
      r_y      <= 4'h0;
      r_n      <= 4'h0;
      r_val    <= 8'h00;
      r_addr   <= 12'h000;
    end else if (r_state == S_DECODE) begin
      r_decode <= w_code;
      // Bnnn jumps relative to V0, so x is steered to register 0
      r_x      <= (r_opcode[15:12] == 4'hB) ? 4'h0 : r_opcode[11:8];
      r_y      <= r_opcode[7:4];
      r_n      <= r_opcode[3:0];
      r_val    <= r_opcode[7:0];
      r_addr   <= r_opcode[11:0];
    end
  end

  // Address and increment follow pc_rd directly: a jump taken by execute in
  // the previous cycle must be visible in the very cycle of the fetch.
  always_comb begin
    w_mem_r_addr = {ADDR_W{1'b0}};
    w_pc_inc_wr  = 16'h0000;
    if (r_mem_r_en) begin
      w_mem_r_addr = bus.pc_rd[ADDR_W-1:0];
    end else begin
      w_mem_r_addr = {ADDR_W{1'b0}};
    end
    if (r_pc_inc_en) begin
      w_pc_inc_wr = bus.pc_rd + 16'd1;
    end else begin
      w_pc_inc_wr = 16'h0000;
    end
  end

  assign bus.mem_r_en   = r_mem_r_en;
  assign bus.mem_r_addr = w_mem_r_addr;
  assign bus.pc_inc_en  = r_pc_inc_en;
  assign bus.pc_inc_wr  = w_pc_inc_wr;
  assign bus.dec_valid  = r_dec_valid;
  assign bus.illegal    = r_illegal;
  assign bus.opcode     = r_opcode;
  assign bus.decode     = r_decode;
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.n          = r_n;
  assign bus.val        = r_val;
  assign bus.addr       = r_addr;

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: self-checking bench for the CHIP-8 fetch/decode stage.
// A small PC register and synchronous program memory model surround the
// DUT; expected decode values come from a mask/match opcode table.
module tb_fetch_decode;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fetch_decode_if #(.ADDR_W(AW)) bus ();

  fetch_decode #(.ADDR_W(AW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // environment: program memory and PC register
  logic [15:0] mem [0:4095];
  logic [15:0] mem_q;
  logic [15:0] pc_q;
  logic [15:0] pc_load_val;
  logic        pc_load;

  // synchronous program memory: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (bus.mem_r_en) mem_q <= mem[bus.mem_r_addr];
  end

  // PC register: bench load, otherwise the fetch stage's increment request
  always @(posedge clk) begin
    if (pc_load) pc_q <= pc_load_val;
    else if (bus.pc_inc_en) pc_q <= bus.pc_inc_wr;
  end

  assign bus.pc_rd      = pc_q;
  assign bus.mem_r_data = mem_q;

  int          n_cmp;
  int          n_bad;
  logic [15:0] exp_pc;

  // reference opcode table: (opcode & mask) == match -> code
  logic [15:0] t_mask[$];
  logic [15:0] t_match[$];
  int          t_code[$];

  task automatic add_pat(input logic [15:0] m, input logic [15:0] v, input int c);
    t_mask.push_back(m);
    t_match.push_back(v);
    t_code.push_back(c);
  endtask

  task automatic build_table;
    add_pat(16'hFFFF, 16'h00E0, 1);
    add_pat(16'hFFFF, 16'h00EE, 2);
    add_pat(16'hF000, 16'h1000, 3);
    add_pat(16'hF000, 16'h2000, 4);
    add_pat(16'hF000, 16'h3000, 5);
    add_pat(16'hF000, 16'h4000, 6);
    add_pat(16'hF00F, 16'h5000, 7);
    add_pat(16'hF000, 16'h6000, 8);
    add_pat(16'hF000, 16'h7000, 9);
    for (int k = 0; k < 8; k++) add_pat(16'hF00F, 16'h8000 + 16'(k), 10 + k);
    add_pat(16'hF00F, 16'h800E, 18);
    add_pat(16'hF00F, 16'h9000, 19);
    add_pat(16'hF000, 16'hA000, 20);
    add_pat(16'hF000, 16'hB000, 21);
    add_pat(16'hF000, 16'hC000, 22);
    add_pat(16'hF000, 16'hD000, 23);
    add_pat(16'hF0FF, 16'hE09E, 24);
    add_pat(16'hF0FF, 16'hE0A1, 25);
    add_pat(16'hF0FF, 16'hF007, 26);
    add_pat(16'hF0FF, 16'hF00A, 27);
    add_pat(16'hF0FF, 16'hF015, 28);
    add_pat(16'hF0FF, 16'hF018, 29);
    add_pat(16'hF0FF, 16'hF01E, 30);
    add_pat(16'hF0FF, 16'hF029, 32);
    add_pat(16'hF0FF, 16'hF033, 33);
    add_pat(16'hF0FF, 16'hF055, 34);
    add_pat(16'hF0FF, 16'hF065, 35);
  endtask

  function automatic int ref_decode(input logic [15:0] op);
    int r;
    r = 0;
    foreach (t_mask[i]) if ((op & t_mask[i]) == t_match[i]) r = t_code[i];
    return r;
  endfunction

  // expected {decode, x, y, n, val, addr, opcode} for an opcode
  function automatic logic [53:0] ref_fields(input logic [15:0] op);
    logic [3:0] ex_x;
    ex_x = (op[15:12] == 4'hB) ? 4'h0 : op[11:8];
    return {6'(ref_decode(op)), ex_x, op[7:4], op[3:0], op[7:0], op[11:0], op};
  endfunction

  function automatic logic [53:0] dut_fields();
    return {bus.decode, bus.x, bus.y, bus.n, bus.val, bus.addr, bus.opcode};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One instruction, entered in its FETCH cycle. Checks the fixed timeline
  // FETCH(T) WAIT(T+1) DECODE(T+2) ISSUE/illegal(T+3), the stall hold and
  // the next fetch (or park) after completion.
  task automatic exec_instr(input logic [15:0] op, input int stall,
                            input bit run_after, input bit noise);
    logic [53:0] exp_f;
    int          code;
    code  = ref_decode(op);
    exp_f = ref_fields(op);
    mem[exp_pc[11:0]] = op;
    bus.ex_done = noise;   // must be ignored before ISSUE
    // FETCH
    n_cmp++;
    if (bus.mem_r_en !== 1'b1) begin
      n_bad++; $display("FAIL fetch_en op=%h: got %b want 1", op, bus.mem_r_en);
    end
    n_cmp++;
    if (bus.mem_r_addr !== exp_pc[11:0]) begin
      n_bad++; $display("FAIL fetch_addr op=%h: got %h want %h", op, bus.mem_r_addr, exp_pc[11:0]);
    end
    tick;
    // WAIT
    n_cmp++;
    if ({bus.mem_r_en, bus.pc_inc_en, bus.dec_valid} !== 3'b000) begin
      n_bad++; $display("FAIL wait_strobes op=%h: got %b want 000", op,
                        {bus.mem_r_en, bus.pc_inc_en, bus.dec_valid});
    end
    tick;
    // DECODE
    n_cmp++;
    if ({bus.pc_inc_en, bus.dec_valid} !== 2'b10) begin
      n_bad++; $display("FAIL pc_inc_en op=%h: got %b want 10", op, {bus.pc_inc_en, bus.dec_valid});
    end
    n_cmp++;
    if (bus.pc_inc_wr !== exp_pc + 16'd1) begin
      n_bad++; $display("FAIL pc_inc_wr op=%h: got %h want %h", op, bus.pc_inc_wr, exp_pc + 16'd1);
    end
    n_cmp++;
    if (bus.opcode !== op) begin
      n_bad++; $display("FAIL opcode_latch: got %h want %h", bus.opcode, op);
    end
    exp_pc  = exp_pc + 16'd1;
    bus.run = run_after;
    tick;
    // T+3
    n_cmp++;
    if (dut_fields() !== exp_f) begin
      n_bad++; $display("FAIL fields op=%h: got %h want %h", op, dut_fields(), exp_f);
    end
    if (code == 0) begin
      n_cmp++;
      if ({bus.illegal, bus.dec_valid, bus.pc_inc_en} !== 3'b100) begin
        n_bad++; $display("FAIL illegal_pulse op=%h: got %b want 100", op,
                          {bus.illegal, bus.dec_valid, bus.pc_inc_en});
      end
      bus.ex_done = 1'b0;
    end else begin
      n_cmp++;
      if ({bus.dec_valid, bus.illegal, bus.pc_inc_en} !== 3'b100) begin
        n_bad++; $display("FAIL issue_strobes op=%h: got %b want 100", op,
                          {bus.dec_valid, bus.illegal, bus.pc_inc_en});
      end
      n_cmp++;
      if (bus.pc_rd !== exp_pc) begin
        n_bad++; $display("FAIL issue_pc op=%h: got %h want %h", op, bus.pc_rd, exp_pc);
      end
      bus.ex_done = (stall == 0);
      tick;
      for (int i = 1; i <= stall; i++) begin
        n_cmp++;
        if ({bus.mem_r_en, bus.dec_valid, bus.pc_inc_en} !== 3'b000 || dut_fields() !== exp_f) begin
          n_bad++; $display("FAIL stall_hold op=%h cyc=%0d: strobes %b fields %h want 000 %h", op, i,
                            {bus.mem_r_en, bus.dec_valid, bus.pc_inc_en}, dut_fields(), exp_f);
        end
        if (i == stall) bus.ex_done = 1'b1;
        tick;
      end
      bus.ex_done = 1'b0;
    end
    n_cmp++;
    if (bus.mem_r_en !== run_after) begin
      n_bad++; $display("FAIL next_fetch op=%h: got %b want %b", op, bus.mem_r_en, run_after);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.ex_done = 1'b0;
    pc_load = 1'b1;
    pc_load_val = 16'h0000;
    tick;
    tick;
    n_cmp++;
    if ({bus.mem_r_en, bus.pc_inc_en, bus.dec_valid, bus.illegal, bus.mem_r_addr, bus.pc_inc_wr} !== 32'h0) begin
      n_bad++; $display("FAIL reset_strobes: got %h want 0",
                        {bus.mem_r_en, bus.pc_inc_en, bus.dec_valid, bus.illegal, bus.mem_r_addr, bus.pc_inc_wr});
    end
    n_cmp++;
    if (dut_fields() !== 54'h0) begin
      n_bad++; $display("FAIL reset_fields: got %h want 0", dut_fields());
    end
    pc_load = 1'b0;
    exp_pc = 16'h0000;
    #2 rst_n = 1'b1;
    tick;
    tick;
    n_cmp++;
    if (bus.mem_r_en !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_run: got %b want 0", bus.mem_r_en);
    end
  endtask

  task automatic test_basic_load;
    bus.run = 1'b1;
    tick;
    exec_instr(16'h6A5C, 0, 1'b1, 1'b0);
  endtask

  task automatic test_arith;
    exec_instr(16'h8124, 1, 1'b1, 1'b0);
    exec_instr(16'h812E, 0, 1'b1, 1'b0);
    exec_instr(16'h8128, 0, 1'b1, 1'b0);
  endtask

  task automatic test_jump;
    exec_instr(16'hB345, 0, 1'b1, 1'b0);
    exec_instr(16'hF229, 2, 1'b1, 1'b0);
    exec_instr(16'h0123, 0, 1'b1, 1'b0);
  endtask

  task automatic test_stall;
    exec_instr(16'hD12F, 10, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    logic [15:0] op;
    int          idx;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        op = 16'($urandom);
      end else begin
        idx = $urandom_range(0, t_mask.size() - 1);
        op  = t_match[idx] | (16'($urandom) & ~t_mask[idx]);
      end
      exec_instr(op, $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid;
    mem[exp_pc[11:0]] = 16'h7123;
    tick;           // WAIT
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_r_en, bus.pc_inc_en, bus.dec_valid, bus.illegal} !== 4'b0000 || dut_fields() !== 54'h0) begin
      n_bad++; $display("FAIL reset_mid: strobes %b fields %h want 0000 0",
                        {bus.mem_r_en, bus.pc_inc_en, bus.dec_valid, bus.illegal}, dut_fields());
    end
    #2 rst_n = 1'b1;
    tick;           // fresh FETCH of the same, un-incremented PC
    n_cmp++;
    if ({bus.dec_valid, bus.pc_inc_en} !== 2'b00) begin
      n_bad++; $display("FAIL reset_no_issue: got %b want 00", {bus.dec_valid, bus.pc_inc_en});
    end
    exec_instr(16'h7123, 0, 1'b1, 1'b0);
  endtask

  task automatic test_park;
    logic [53:0] exp_f;
    exp_f = ref_fields(16'hA2F0);
    exec_instr(16'hA2F0, 3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.mem_r_en !== 1'b0 || dut_fields() !== exp_f) begin
        n_bad++; $display("FAIL park_hold cyc=%0d: en %b fields %h want 0 %h", i, bus.mem_r_en, dut_fields(), exp_f);
      end
      tick;
    end
  endtask

  task automatic test_wrap;
    pc_load = 1'b1;
    pc_load_val = 16'hFFFF;
    tick;
    pc_load = 1'b0;
    exp_pc = 16'hFFFF;
    bus.run = 1'b1;
    tick;
    exec_instr(16'h3F00, 0, 1'b1, 1'b0);
    exec_instr(16'h00EE, 0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    build_table();
    test_reset();
    test_basic_load();
    test_arith();
    test_jump();
    test_stall();
    test_random();
    test_reset_mid();
    test_park();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
